handshake_initiator: RTL and testbench

HANDSHAKE_INITIATOR -- requirements
Module: handshake_initiator

---
 rtl/handshake_initiator.sv | 158 +++++++++++++++
 tb/tb_handshake_initiator.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_initiator.sv
// Four-phase bundled-data initiator: accepts words from a synchronous
// valid/ready producer and delivers each one to an asynchronous receiver
// with a req/ack four-phase handshake, guarded by a per-phase timeout.
module handshake_initiator #(
  parameter int unsigned DW           = 8,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          req,
  output logic [DW-1:0] data,
  input  logic          ack,
  output logic          busy,
  output logic          timeout_err,
  input  logic          clr_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    REQ_HI = 3'd2,
    REQ_LO = 3'd3,
    ERR    = 3'd4
  } state_e;

  // Setup count loaded at acceptance; the last wait-count value before timeout.
  localparam logic [3:0]  SETUP_LOAD = 4'(SETUP_CYCLES);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          ack_meta_q, ack_s_q;
  logic [DW-1:0] data_q, data_d;
  logic [3:0]    setup_cnt_q, setup_cnt_d;
  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic          req_q, req_d;
  logic          terr_q, terr_d;
  logic          wait_hit;

  // Two-flop synchronizer: ack is asynchronous, only ack_s_q is ever used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Next-state, payload, counter and flag logic for the handshake FSM.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    setup_cnt_d = setup_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    terr_d      = terr_q;
    wait_hit    = (wait_cnt_q == WAIT_LAST);

    case (state_q)
      IDLE: begin
        // in_ready is 1 here, so in_valid alone means acceptance.
        if (in_valid) begin
          data_d      = in_data;
          setup_cnt_d = SETUP_LOAD;
          state_d     = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (setup_cnt_q != 4'd0) begin
          setup_cnt_d = setup_cnt_q - 4'd1;
        end else begin
          setup_cnt_d = 4'd0;
        end
        // Raise req once the bundling delay has elapsed, but never on a
        // stale ack still high from a previous (possibly reset) transfer.
        if ((setup_cnt_q <= 4'd1) && !ack_s_q) begin
          state_d    = REQ_HI;
          wait_cnt_d = 16'd0;
        end else begin
          state_d = SETUP;
        end
      end
      REQ_HI: begin
        // The ack test comes first so a handshake on the timeout edge wins.
        if (ack_s_q) begin
          state_d    = REQ_LO;
          wait_cnt_d = 16'd0;
        end else if (wait_hit) begin
          state_d    = ERR;
          terr_d     = 1'b1;
          wait_cnt_d = 16'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      REQ_LO: begin
        if (!ack_s_q) begin
          state_d    = IDLE;
          wait_cnt_d = 16'd0;
        end else if (wait_hit) begin
          state_d    = ERR;
          terr_d     = 1'b1;
          wait_cnt_d = 16'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ERR: begin
        // Only leave once the receiver has released ack, so the next
        // transfer cannot start against a stale acknowledge.
        if (clr_err && !ack_s_q) begin
          state_d = IDLE;
          terr_d  = 1'b0;
        end else begin
          state_d = ERR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // req is registered from the next state, so it is a clean flop output.
    req_d = (state_d == REQ_HI);
  end

  // State, payload, counters, req and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      setup_cnt_q <= 4'd0;
      wait_cnt_q  <= 16'd0;
      req_q       <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      setup_cnt_q <= setup_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      req_q       <= req_d;
      terr_q      <= terr_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign req         = req_q;
  assign data        = data_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_handshake_initiator.sv
// Self-checking bench for handshake_initiator: edge-accurate expectations
// derived from the handshake timing rules, with randomized words and
// receiver response delays.
module tb_handshake_initiator;
  localparam int DW = 8;
  localparam int SC = 2;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          req;
  logic [DW-1:0] data;
  logic          ack;
  logic          busy;
  logic          timeout_err;
  logic          clr_err;

  int n_pass  = 0;
  int n_total = 0;
  int ecnt    = 0;

  int acc_t [3];
  int rise_t[3];
  int fall_t[3];
  int idle_t[3];
  bit stable_ok;

  handshake_initiator #(.DW(DW), .SETUP_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .req(req), .data(data), .ack(ack),
    .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  // Offers n words (held valid), plays a receiver that raises ack d edges
  // after seeing req and drops it e edges after seeing req fall; records
  // the edge of each event.
  task automatic run_words(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input int n, input int d, input int e);
    logic [7:0] w [3];
    int   x;
    int   k;
    logic rdy;
    w[0] = w0; w[1] = w1; w[2] = w2;
    x = -1; k = 0; stable_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      acc_t[i] = -1; rise_t[i] = -1; fall_t[i] = -1; idle_t[i] = -1;
    end
    in_valid = 1'b1;
    in_data  = w[0];
    for (int c = 0; c < 300; c++) begin
      rdy = in_ready;
      tick();
      if (rdy && in_valid) begin
        x = k;
        acc_t[x] = ecnt;
        k++;
        if (k < n) in_data = w[k];
        else begin
          in_valid = 1'b0;
          in_data  = 8'h00;
        end
      end
      if (x >= 0) begin
        if (data !== w[x]) stable_ok = 1'b0;
        if (rise_t[x] < 0) begin
          if (req === 1'b1) rise_t[x] = ecnt;
        end else if (fall_t[x] < 0) begin
          if (req === 1'b0) fall_t[x] = ecnt;
        end else if (idle_t[x] < 0) begin
          if (in_ready === 1'b1) idle_t[x] = ecnt;
        end
        if (rise_t[x] >= 0 && fall_t[x] < 0 && ecnt == rise_t[x] + d - 1) ack = 1'b1;
        if (fall_t[x] >= 0 && ecnt == fall_t[x] + e - 1) ack = 1'b0;
        if (idle_t[x] >= 0 && x == n - 1) break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Plays a prompt receiver until the FSM is back in IDLE.
  task automatic finish_handshake(output bit ok);
    ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (req === 1'b1) break;
      tick();
    end
    if (req !== 1'b1) ok = 1'b0;
    ack = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (req === 1'b0) break;
      tick();
    end
    if (req !== 1'b0) ok = 1'b0;
    ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (in_ready === 1'b1) break;
      tick();
    end
    if (in_ready !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ack = 1'b0; clr_err = 1'b0;
    #12;
    got = {req, busy, in_ready, timeout_err, data};
    n_total++;
    if (got !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00})
      $display("FAIL reset_state: got %b required %b", got, {1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int a;
    run_words(8'hA5, 8'h00, 8'h00, 1, 3, 2);
    a = acc_t[0];
    n_total++;
    if (rise_t[0] - a !== 2) $display("FAIL single_req_rise: got edge %0d required 2", rise_t[0] - a);
    else n_pass++;
    n_total++;
    if (fall_t[0] - a !== 7) $display("FAIL single_req_fall: got edge %0d required 7", fall_t[0] - a);
    else n_pass++;
    n_total++;
    if (idle_t[0] - a !== 11) $display("FAIL single_idle: got edge %0d required 11", idle_t[0] - a);
    else n_pass++;
    n_total++;
    if (!stable_ok || data !== 8'hA5) $display("FAIL single_data: got %h stable %0d required a5 stable 1", data, stable_ok);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] w;
    int d, e, s;
    for (int i = 0; i < 8; i++) begin
      w = 8'($urandom);
      d = int'($urandom_range(1, TO - 2));
      e = int'($urandom_range(1, TO - 2));
      s = ecnt;
      run_words(w, 8'h00, 8'h00, 1, d, e);
      n_total++;
      if (acc_t[0] !== s + 1) $display("FAIL rand_accept: got edge %0d required %0d", acc_t[0], s + 1);
      else n_pass++;
      n_total++;
      if (rise_t[0] !== acc_t[0] + SC) $display("FAIL rand_rise: got edge %0d required %0d", rise_t[0], acc_t[0] + SC);
      else n_pass++;
      n_total++;
      if (fall_t[0] !== rise_t[0] + d + 2) $display("FAIL rand_fall d=%0d: got edge %0d required %0d", d, fall_t[0], rise_t[0] + d + 2);
      else n_pass++;
      n_total++;
      if (idle_t[0] !== fall_t[0] + e + 2) $display("FAIL rand_idle e=%0d: got edge %0d required %0d", e, idle_t[0], fall_t[0] + e + 2);
      else n_pass++;
      n_total++;
      if (!stable_ok || data !== w) $display("FAIL rand_data: got %h stable %0d required %h stable 1", data, stable_ok, w);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    run_words(8'h01, 8'h02, 8'h03, 3, 3, 3);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (rise_t[i] !== acc_t[i] + SC || fall_t[i] !== rise_t[i] + 5 || idle_t[i] !== fall_t[i] + 5)
        $display("FAIL b2b_cycle%0d: got acc %0d rise %0d fall %0d idle %0d required rise acc+2 fall rise+5 idle fall+5",
                 i, acc_t[i], rise_t[i], fall_t[i], idle_t[i]);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (acc_t[i] !== idle_t[i-1] + 1)
          $display("FAIL b2b_gap%0d: got accept edge %0d required %0d", i, acc_t[i], idle_t[i-1] + 1);
        else n_pass++;
      end
    end
    n_total++;
    if (!stable_ok || data !== 8'h03) $display("FAIL b2b_data: got %h stable %0d required 03 stable 1", data, stable_ok);
    else n_pass++;
  endtask

  task automatic test_handshake_race();
    // Ack seen on exactly the timeout edge in both phases: handshake wins.
    run_words(8'h5A, 8'h00, 8'h00, 1, TO - 2, TO - 2);
    n_total++;
    if (fall_t[0] !== rise_t[0] + TO || idle_t[0] !== fall_t[0] + TO)
      $display("FAIL race: got rise %0d fall %0d idle %0d required fall rise+%0d idle fall+%0d",
               rise_t[0], fall_t[0], idle_t[0], TO, TO);
    else n_pass++;
    n_total++;
    if (timeout_err !== 1'b0) $display("FAIL race_err: got %b required 0", timeout_err);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int r, te;
    logic req_at, busy_at;
    ack = 1'b0; in_valid = 1'b1; in_data = 8'($urandom);
    tick();
    in_valid = 1'b0;
    r = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (req === 1'b1) begin r = ecnt; break; end
    end
    n_total++;
    if (r < 0) $display("FAIL to_req_rise: got no req required req rise");
    else n_pass++;
    te = -1; req_at = 1'b1; busy_at = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (clr_err) begin
        clr_err = 1'b0;
        n_total++;
        if (req !== 1'b1) $display("FAIL to_clr_outside_err: got req %b required 1", req);
        else n_pass++;
      end
      if (timeout_err === 1'b1) begin te = ecnt; req_at = req; busy_at = busy; break; end
      if (ecnt == r + 3) clr_err = 1'b1;
    end
    n_total++;
    if (te !== r + TO || req_at !== 1'b0 || busy_at !== 1'b1)
      $display("FAIL to_enter_err: got edge %0d req %b busy %b required edge %0d req 0 busy 1", te, req_at, busy_at, r + TO);
    else n_pass++;
    tick(); tick(); tick();
    n_total++;
    if (timeout_err !== 1'b1 || busy !== 1'b1) $display("FAIL to_err_sticky: got err %b busy %b required 1 1", timeout_err, busy);
    else n_pass++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_total++;
    if (timeout_err !== 1'b0 || in_ready !== 1'b1) $display("FAIL to_clear: got err %b ready %b required 0 1", timeout_err, in_ready);
    else n_pass++;
  endtask

  task automatic test_err_clear_blocked();
    int r, f, te;
    in_valid = 1'b1; in_data = 8'($urandom);
    tick();
    in_valid = 1'b0;
    r = -1; f = -1; te = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (r < 0 && req === 1'b1) begin r = ecnt; ack = 1'b1; end
      else if (r >= 0 && f < 0 && req === 1'b0) f = ecnt;
      if (f >= 0 && timeout_err === 1'b1) begin te = ecnt; break; end
    end
    n_total++;
    if (f !== r + 3 || te !== f + TO)
      $display("FAIL blk_lo_timeout: got rise %0d fall %0d err %0d required fall rise+3 err fall+%0d", r, f, te, TO);
    else n_pass++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    n_total++;
    if (timeout_err !== 1'b1 || busy !== 1'b1) $display("FAIL blk_clr_with_ack: got err %b busy %b required 1 1", timeout_err, busy);
    else n_pass++;
    ack = 1'b0;
    tick(); tick(); tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_total++;
    if (timeout_err !== 1'b0 || in_ready !== 1'b1) $display("FAIL blk_clr_released: got err %b ready %b required 0 1", timeout_err, in_ready);
    else n_pass++;
  endtask

  task automatic test_stuck_ack();
    bit stall_ok, ok;
    int j;
    ack = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    stall_ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (req !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
    end
    n_total++;
    if (!stall_ok) $display("FAIL stuck_stall: got req high or not busy required req 0 busy 1");
    else n_pass++;
    ack = 1'b0;
    j = ecnt;
    tick(); tick();
    n_total++;
    if (req !== 1'b0) $display("FAIL stuck_early_req: got req %b at edge +%0d required 0", req, ecnt - j);
    else n_pass++;
    tick();
    n_total++;
    if (req !== 1'b1) $display("FAIL stuck_release_req: got req %b at edge +%0d required 1", req, ecnt - j);
    else n_pass++;
    finish_handshake(ok);
    n_total++;
    if (!ok || data !== 8'h3C) $display("FAIL stuck_complete: got ok %0d data %h required 1 3c", ok, data);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic [11:0] got;
    bit stall_ok, ok;
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (req === 1'b1) break;
      tick();
    end
    ack = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    got = {req, busy, in_ready, timeout_err, data};
    n_total++;
    if (got !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00})
      $display("FAIL rst_mid_op: got %b required %b", got, {1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h96;
    tick();
    in_valid = 1'b0;
    stall_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (req !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
    end
    n_total++;
    if (!stall_ok || data !== 8'h96) $display("FAIL rst_stale_ack_stall: got stall %0d data %h required 1 96", stall_ok, data);
    else n_pass++;
    ack = 1'b0;
    finish_handshake(ok);
    n_total++;
    if (!ok) $display("FAIL rst_recover: got handshake incomplete required complete");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_handshake_race();
    test_timeout();
    test_err_clear_blocked();
    test_stuck_ack();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
